lsu_ram_master: RTL and testbench
=================================

Name: lsu_ram_master

Overview:
Load/store initiator between the pipeline MEM stage and the synchronous dual-port data RAM. The RAM has a 1-cycle registered read, word addressing [31:2] and per-byte write enables. This block accepts byte, half and word requests at any byte address. It generates byte enables and lane-shifted store data, and splits word-crossing accesses into two RAM cycles. For loads it merges, extracts and sign- or zero-extends the returned data. It drives one RAM port.

Parameters:
ADDR_BITS, 14, byte-address width backed by RAM; addr[31:ADDR_BITS] must be 0 or the access faults

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_unsigned  in  1  load zero-extend (1) or sign-extend (0)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  fault flag, valid with resp_valid
resp_rdata  out  32  load result, valid with resp_valid; 0 for stores and faults
ram_addr  out  30  word address [31:2] to RAM
ram_we  out  4  byte write enables, bit i = byte lane i
ram_din  out  32  lane-shifted store data
ram_dout  in  32  RAM read data, valid the cycle after ram_addr is sampled

Behaviour:
- Byte order is little-endian. off = addr[1:0]. nbytes = 1, 2 or 4.
- Split condition: off + nbytes > 4.
- Lane mask = ((1<<nbytes)-1) << off. Bits [3:0] go to word W = addr[31:2]; bits [7:4] go to W+1.
- Store data is shifted left by 8*off. The low 32 bits go to W and the high bits go to W+1.
- Fault conditions: req_size = 3; or (addr + nbytes - 1)[31:ADDR_BITS] != 0, which checks both words of a split access.
- On fault: no RAM write; resp_valid next cycle with resp_err = 1 and resp_rdata = 0. No further states.
- States: IDLE, RD1, RD2, WR2.
- req_ready = (state == IDLE). A request is accepted when req_valid && req_ready.
- In IDLE, ram_addr, ram_we and ram_din are combinational from the request, so the first RAM access happens on the accept edge. When nothing is accepted, ram_we = 0. ram_addr/ram_din are don't-care.
- Aligned store: write on the accept edge; resp_valid in cycle +1; stays in IDLE.
- Split store: high-part lanes are nonzero; the low part is written on the accept edge. WR2 then writes W+1 with the high lanes and data from registers. resp_valid in cycle +2.
- Load: read W on the accept edge; go to RD1.
  - RD1, no split: extract bytes at off from ram_dout and extend. Register the result; resp_valid in the next cycle. Go to IDLE.
  - RD1, split: latch ram_dout as the low word and issue a read of W+1 (ram_we = 0). Go to RD2.
  - RD2: form the 64-bit value {ram_dout, low}, shift right by 8*off, then extend. resp_valid next cycle. Go to IDLE.
- Load latency: 2 cycles accept-to-resp aligned, 3 cycles split.
- Extension: byte from bit 7, half from bit 15, or zero-fill when req_unsigned. Word loads pass through.
- resp_valid, resp_err and resp_rdata are registered. resp_valid is high for exactly one cycle.
- A new request may be accepted in the same cycle resp_valid is high, because the state is IDLE then.
- Request fields are captured at accept; the requester may change them afterwards.
- Reset (asynchronous, any state): state = IDLE; resp_valid = 0, resp_err = 0, resp_rdata = 0; internal registers cleared.
  - ram_we = 0 while rst_n is low, even when req_valid is high.
  - A split store interrupted by reset before WR2 leaves only the low part written. This is accepted behaviour.
  - Any load in flight is dropped with no response.

Test Plan:
- Aligned word store then load: sw 0xDEADBEEF @0x100 → ram_we = 4'hF, ram_addr = 0x40, resp in cycle +1. lw @0x100 → resp_rdata = 0xDEADBEEF at cycle +2, resp_err = 0.
- Byte and half extension: word 0x80F17F02 @0x200.
  - lb @0x203 → 0xFFFFFF80; lbu @0x203 → 0x00000080.
  - lh @0x202 → 0xFFFF80F1; lhu @0x200 → 0x00007F02.
- Sub-word store: sb 0xAB @0x301 → ram_we = 4'b0010, ram_din[15:8] = 0xAB. Other bytes of the word are unchanged on readback.
- Split word store and load: sw 0x11223344 @0x0FE.
  - Cycle 0: ram_addr 0x3F, ram_we 4'b1100.
  - Cycle 1: ram_addr 0x40, ram_we 4'b0011.
  - resp at cycle 2.
  - lw @0x0FE returns 0x11223344 at cycle 3.
- Faults: lw @0x00004000, or sh @0x3FFF (second byte out of range), or req_size = 3 → no ram_we activity; resp_err = 1, resp_rdata = 0 at cycle +1.
- Reset mid-operation: assert rst_n = 0 in RD2 of a split load → ram_we = 0 and resp_valid = 0 immediately. After release, req_ready = 1 and no stale response appears.

Source files
------------

// File: rtl/lsu_ram_master.sv
// Load/store initiator for a synchronous single-cycle-read data RAM port.
// Handles byte/half/word at any byte address, splitting word-crossing accesses into two RAM cycles.
module lsu_ram_master #(
  parameter int ADDR_BITS = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [29:0] ram_addr,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE. resp_valid is a one-cycle pulse with resp_err/resp_rdata.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD1  = 2'd1,
    S_RD2  = 2'd2,
    S_WR2  = 2'd3
  } state_t;

  localparam logic [31:0] HI_MASK = ~((32'd1 << ADDR_BITS) - 32'd1);

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_off;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic        r_split;
  logic [29:0] r_addr_hi;
  logic [3:0]  r_hi_we;
  logic [31:0] r_hi_din;
  logic [31:0] r_low;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;

  logic [2:0]  w_nbytes;
  logic [3:0]  w_lane4;
  logic [7:0]  w_mask8;
  logic [63:0] w_data64;
  logic [31:0] w_last;
  logic        w_fault;
  logic        w_split;
  logic        w_accept;
  logic [63:0] w_rd64;
  logic [31:0] w_sh32;
  logic [31:0] w_ext;
  logic        w_resp_valid_d;
  logic        w_resp_err_d;
  logic [31:0] w_resp_rdata_d;

  always_comb begin
    w_nbytes = 3'd4;
    w_lane4  = 4'b1111;
    case (req_size)
      2'd0: begin w_nbytes = 3'd1; w_lane4 = 4'b0001; end
      2'd1: begin w_nbytes = 3'd2; w_lane4 = 4'b0011; end
      default: ;
    endcase
  end

  assign w_mask8  = {4'b0000, w_lane4} << req_addr[1:0];
  assign w_data64 = {32'd0, req_wdata} << {req_addr[1:0], 3'b000};
  assign w_last   = req_addr + {29'd0, w_nbytes} - 32'd1;
  // Checking both ends covers the second word of a split access as well as address wrap.
  assign w_fault  = (req_size == 2'd3) | (|(req_addr & HI_MASK)) | (|(w_last & HI_MASK));
  assign w_split  = |w_mask8[7:4];
  assign w_accept = req_valid & (r_state == S_IDLE);

  assign w_rd64 = (r_state == S_RD2) ? {ram_dout, r_low} : {32'd0, ram_dout};
  assign w_sh32 = 32'(w_rd64 >> {r_off, 3'b000});

  always_comb begin
    w_ext = w_sh32;
    case (r_size)
      2'd0: w_ext = r_unsigned ? {24'd0, w_sh32[7:0]} : {{24{w_sh32[7]}}, w_sh32[7:0]};
      2'd1: w_ext = r_unsigned ? {16'd0, w_sh32[15:0]} : {{16{w_sh32[15]}}, w_sh32[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    w_state_next   = r_state;
    w_resp_valid_d = 1'b0;
    w_resp_err_d   = 1'b0;
    w_resp_rdata_d = 32'd0;
    ram_addr       = req_addr[31:2];
    ram_we         = 4'b0000;
    ram_din        = w_data64[31:0];
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_fault) begin
            w_resp_valid_d = 1'b1;
            w_resp_err_d   = 1'b1;
          end else if (req_we) begin
            ram_we = w_mask8[3:0];
            if (w_split) w_state_next = S_WR2;
            else         w_resp_valid_d = 1'b1;
          end else begin
            w_state_next = S_RD1;
          end
        end
      end
      S_RD1: begin
        ram_addr = r_addr_hi;
        if (r_split) begin
          w_state_next = S_RD2;
        end else begin
          w_state_next   = S_IDLE;
          w_resp_valid_d = 1'b1;
          w_resp_rdata_d = w_ext;
        end
      end
      S_RD2: begin
        w_state_next   = S_IDLE;
        w_resp_valid_d = 1'b1;
        w_resp_rdata_d = w_ext;
      end
      S_WR2: begin
        ram_addr       = r_addr_hi;
        ram_we         = r_hi_we;
        ram_din        = r_hi_din;
        w_state_next   = S_IDLE;
        w_resp_valid_d = 1'b1;
      end
      default: w_state_next = S_IDLE;
    endcase
    // The RAM must never see a write while reset is held, even with a request present.
    if (!rst_n) ram_we = 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_off        <= 2'd0;
      r_size       <= 2'd0;
      r_unsigned   <= 1'b0;
      r_split      <= 1'b0;
      r_addr_hi    <= 30'd0;
      r_hi_we      <= 4'd0;
      r_hi_din     <= 32'd0;
      r_low        <= 32'd0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
    end else begin
      r_state      <= w_state_next;
      r_resp_valid <= w_resp_valid_d;
      r_resp_err   <= w_resp_err_d;
      r_resp_rdata <= w_resp_rdata_d;
      if (w_accept) begin
        r_off      <= req_addr[1:0];
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_split    <= w_split;
        r_addr_hi  <= req_addr[31:2] + 30'd1;
        r_hi_we    <= w_mask8[7:4];
        r_hi_din   <= w_data64[63:32];
      end
      if (r_state == S_RD1) r_low <= ram_dout;
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_lsu_ram_master.sv
// Directed bench for lsu_ram_master with a behavioural 1-cycle-read RAM on the port.
// Expected values are hand-computed from the little-endian lane rules.
module tb_lsu_ram_master;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [29:0] ram_addr;
  logic [3:0]  ram_we;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic [1:0]  dbg_state;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [29:0] o_addr0, o_addr1;
  logic [3:0]  o_we0, o_we1;
  logic [31:0] o_din0, o_din1;
  logic [1:0]  o_dbg1;
  int          o_lat;
  logic [31:0] o_rdata;
  logic        o_err;
  logic        o_after;
  logic        seen_resp;

  lsu_ram_master #(.ADDR_BITS(14)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_din(ram_din), .ram_dout(ram_dout), .dbg_state(dbg_state)
  );

  // clock / RAM model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (ram_we[i]) mem[ram_addr[11:0]][8*i +: 8] <= ram_din[8*i +: 8];
    ram_dout <= mem[ram_addr[11:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request starting just after a rising edge; record RAM activity on
  // the accept cycle and the next, the response latency and the pulse width.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    #1;
    o_addr0 = ram_addr; o_we0 = ram_we; o_din0 = ram_din;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = $urandom_range(0, 1); req_size = 2'($urandom_range(0, 3));
    req_unsigned = $urandom_range(0, 1); req_addr = $urandom; req_wdata = $urandom;
    #1;
    o_addr1 = ram_addr; o_we1 = ram_we; o_din1 = ram_din; o_dbg1 = dbg_state;
    o_lat = 1;
    while (!resp_valid && o_lat < 10) begin
      @(posedge clk); #1;
      o_lat++;
    end
    o_rdata = resp_rdata; o_err = resp_err;
    @(posedge clk); #1;
    o_after = resp_valid;
  endtask

  task automatic load(input string tag, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] exp, input int lat);
    issue(1'b0, size, uns, addr, 32'd0);
    chk({tag, "_data"}, o_rdata, exp);
    chk({tag, "_lat"}, 32'(o_lat), 32'(lat));
    chk({tag, "_err"}, {31'd0, o_err}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
    req_unsigned = 1'b0; req_addr = 32'h100; req_wdata = 32'hFFFF_FFFF;
    #1;
    chk("rst_ram_we", {28'd0, ram_we}, 32'd0);
    @(posedge clk); #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_ram_we2", {28'd0, ram_we}, 32'd0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // aligned word store then load
    issue(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF);
    chk("sw_we", {28'd0, o_we0}, 32'hF);
    chk("sw_addr", {2'd0, o_addr0}, 32'h40);
    chk("sw_din", o_din0, 32'hDEAD_BEEF);
    chk("sw_lat", 32'(o_lat), 32'd1);
    chk("sw_rdata", o_rdata, 32'd0);
    chk("sw_pulse", {31'd0, o_after}, 32'd0);
    load("lw", 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF, 2);
    chk("lw_we", {28'd0, o_we0}, 32'd0);
    chk("lw_pulse", {31'd0, o_after}, 32'd0);

    // sign / zero extension
    issue(1'b1, 2'd2, 1'b0, 32'h200, 32'h80F1_7F02);
    load("lb", 2'd0, 1'b0, 32'h203, 32'hFFFF_FF80, 2);
    load("lbu", 2'd0, 1'b1, 32'h203, 32'h0000_0080, 2);
    load("lh", 2'd1, 1'b0, 32'h202, 32'hFFFF_80F1, 2);
    load("lhu", 2'd1, 1'b1, 32'h200, 32'h0000_7F02, 2);
    load("lb_pos", 2'd0, 1'b0, 32'h201, 32'h0000_007F, 2);

    // sub-word store leaves other lanes alone
    issue(1'b1, 2'd2, 1'b0, 32'h300, 32'h4433_2211);
    issue(1'b1, 2'd0, 1'b0, 32'h301, 32'hFFFF_FFAB);
    chk("sb_we", {28'd0, o_we0}, 32'h2);
    chk("sb_din", {24'd0, o_din0[15:8]}, 32'hAB);
    chk("sb_lat", 32'(o_lat), 32'd1);
    load("sb_rb", 2'd2, 1'b0, 32'h300, 32'h4433_AB11, 2);

    // split word store and load
    issue(1'b1, 2'd2, 1'b0, 32'h0FE, 32'h1122_3344);
    chk("ssw_addr0", {2'd0, o_addr0}, 32'h3F);
    chk("ssw_we0", {28'd0, o_we0}, 32'hC);
    chk("ssw_din0", {16'd0, o_din0[31:16]}, 32'h3344);
    chk("ssw_state1", {30'd0, o_dbg1}, 32'd3);
    chk("ssw_addr1", {2'd0, o_addr1}, 32'h40);
    chk("ssw_we1", {28'd0, o_we1}, 32'h3);
    chk("ssw_din1", {16'd0, o_din1[15:0]}, 32'h1122);
    chk("ssw_lat", 32'(o_lat), 32'd2);
    chk("ssw_pulse", {31'd0, o_after}, 32'd0);
    load("slw", 2'd2, 1'b0, 32'h0FE, 32'h1122_3344, 3);
    load("slw_hi", 2'd2, 1'b0, 32'h100, 32'hDEAD_1122, 2);
    load("slh", 2'd1, 1'b0, 32'h0FF, 32'h0000_2233, 3);

    // faults
    issue(1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'd0);
    chk("flw_err", {31'd0, o_err}, 32'd1);
    chk("flw_rdata", o_rdata, 32'd0);
    chk("flw_lat", 32'(o_lat), 32'd1);
    issue(1'b1, 2'd1, 1'b0, 32'h0000_3FFF, 32'h0000_BEEF);
    chk("fsh_we0", {28'd0, o_we0}, 32'd0);
    chk("fsh_we1", {28'd0, o_we1}, 32'd0);
    chk("fsh_err", {31'd0, o_err}, 32'd1);
    chk("fsh_lat", 32'(o_lat), 32'd1);
    issue(1'b1, 2'd3, 1'b0, 32'h100, 32'h5555_5555);
    chk("fsz_we0", {28'd0, o_we0}, 32'd0);
    chk("fsz_err", {31'd0, o_err}, 32'd1);
    chk("fsz_rdata", o_rdata, 32'd0);
    load("fsz_rb", 2'd2, 1'b0, 32'h100, 32'hDEAD_1122, 2);

    // reset during RD2 of a split load
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h0FE;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid_rd1", {30'd0, dbg_state}, 32'd1);
    @(posedge clk); #1;
    chk("mid_rd2", {30'd0, dbg_state}, 32'd2);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h100; req_wdata = 32'h0;
    rst_n = 1'b0;
    #1;
    chk("mid_ram_we", {28'd0, ram_we}, 32'd0);
    chk("mid_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("mid_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b1;
    seen_resp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      seen_resp = seen_resp | resp_valid;
    end
    chk("mid_no_stale", {31'd0, seen_resp}, 32'd0);
    chk("mid_ready2", {31'd0, req_ready}, 32'd1);
    load("mid_rb", 2'd2, 1'b0, 32'h100, 32'hDEAD_1122, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
